// File: rtl/pix_fetch_pkg.sv
// Shared constants and FSM state type for the line prefetcher.
package pix_fetch_pkg;

  localparam int IMG_W_DEF = 300;
  localparam int IMG_H_DEF = 300;

  localparam logic [7:0] BLANK_PIX = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/line_buf_dp.sv
// 512x8 simple dual-port line buffer: one write port, one registered read port.
module line_buf_dp (
  input  logic       clk,
  input  logic       we,
  input  logic [8:0] waddr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  logic [8:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:511];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pix_line_fetch.sv
// Ping-pong line prefetcher feeding the VGA timing stage from frame memory.
// Optional build macro PIX_FETCH_UNDERRUN_CNT_EN adds the underrun_cnt output.
module pix_line_fetch
  import pix_fetch_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int ADDR_W  = 18,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] offset,
  input  logic              line_req,
  input  logic [8:0]        line_idx,
  input  logic              line_swap,
  input  logic              pix_en,
  input  logic [8:0]        pix_x,
  output logic [7:0]        color,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [7:0]        mem_readdata,
  input  logic              mem_readdatavalid,
  output logic              busy,
  output logic              underrun,
  output logic              req_err,
  input  logic              flag_clr
`ifdef PIX_FETCH_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam logic [9:0] IMG_W_L   = 10'(IMG_W);
  localparam logic [9:0] IMG_H_L   = 10'(IMG_H);
  localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] line_base_reg;
  logic [ADDR_W-1:0] mem_address_reg;
  logic              mem_read_reg;
  logic              busy_reg;
  logic              underrun_reg;
  logic              req_err_reg;
  logic              front_reg;
  logic              tgt_reg;
  logic              discard_reg;
  logic [1:0]        blank_reg;
  logic [9:0]        issue_cnt_reg;
  logic [9:0]        wr_ptr_reg;
  logic [3:0]        outst_reg;
  logic              rd_valid_reg;
  logic              rd_sel_reg;

  logic              accepted;
  logic              rsp;
  logic              abort_now;
  logic              wr_en;
  logic              line_ok;
  logic              pix_ok;
  logic              underrun_set;
  logic              req_err_set;
  logic [9:0]        issue_cnt_next;
  logic [3:0]        outst_next;
  logic [ADDR_W-1:0] line_base_calc;
  logic [7:0]        bank_rdata [2];

  assign accepted       = mem_read_reg && !mem_waitrequest;
  // Responses arriving with nothing outstanding (e.g. left over from before a reset) are ignored.
  assign rsp            = mem_readdatavalid && (state_reg != IDLE) && (outst_reg != 4'd0);
  assign abort_now      = (state_reg == ISSUE) && (line_swap || frame_start);
  assign wr_en          = rsp && !discard_reg && !abort_now && (wr_ptr_reg < IMG_W_L);
  assign issue_cnt_next = issue_cnt_reg + 10'(accepted);
  assign outst_next     = outst_reg + 4'(accepted) - 4'(rsp);
  assign line_ok        = {1'b0, line_idx} < IMG_H_L;
  assign pix_ok         = pix_en && ({1'b0, pix_x} < IMG_W_L);
  assign underrun_set   = abort_now && line_swap;
  assign req_err_set    = line_req && (state_reg != IDLE);
  assign line_base_calc = base_reg + ADDR_W'(line_idx) * ADDR_W'(IMG_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      base_reg        <= '0;
      line_base_reg   <= '0;
      mem_address_reg <= '0;
      mem_read_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      underrun_reg    <= 1'b0;
      req_err_reg     <= 1'b0;
      front_reg       <= 1'b0;
      tgt_reg         <= 1'b1;
      discard_reg     <= 1'b0;
      blank_reg       <= 2'b11;
      issue_cnt_reg   <= '0;
      wr_ptr_reg      <= '0;
      outst_reg       <= '0;
    end else begin
      if (frame_start) base_reg <= offset;
      if (line_swap) front_reg <= ~front_reg;

      if (flag_clr) begin
        underrun_reg <= 1'b0;
        req_err_reg  <= 1'b0;
      end
      if (underrun_set) underrun_reg <= 1'b1;
      if (req_err_set) req_err_reg <= 1'b1;

      outst_reg     <= outst_next;
      issue_cnt_reg <= issue_cnt_next;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 10'd1;

      case (state_reg)
        IDLE: begin
          mem_read_reg <= 1'b0;
          if (line_req) begin
            if (line_ok) begin
              line_base_reg        <= line_base_calc;
              issue_cnt_reg        <= '0;
              wr_ptr_reg           <= '0;
              outst_reg            <= '0;
              tgt_reg              <= ~front_reg;
              blank_reg[~front_reg] <= 1'b0;
              discard_reg          <= 1'b0;
              busy_reg             <= 1'b1;
              state_reg            <= ISSUE;
            end else begin
              blank_reg[~front_reg] <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (abort_now) begin
            mem_read_reg <= 1'b0;
            discard_reg  <= 1'b1;
            state_reg    <= DRAIN;
          end else if (mem_read_reg && mem_waitrequest) begin
            mem_read_reg <= 1'b1;
          end else if (issue_cnt_next == IMG_W_L) begin
            mem_read_reg <= 1'b0;
            state_reg    <= DRAIN;
          end else if (outst_next < MAX_OUT_L) begin
            mem_read_reg    <= 1'b1;
            mem_address_reg <= line_base_reg + ADDR_W'(issue_cnt_next);
          end else begin
            mem_read_reg <= 1'b0;
          end
        end
        DRAIN: begin
          mem_read_reg <= 1'b0;
          if (outst_next == 4'd0) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Display side: bank select and blanking are captured with the read so a swap applies from the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_reg <= 1'b0;
      rd_sel_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= pix_ok && !blank_reg[front_reg];
      rd_sel_reg   <= front_reg;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    line_buf_dp u_buf (
      .clk   (clk),
      .we    (wr_en && (tgt_reg == 1'(gi))),
      .waddr (wr_ptr_reg[8:0]),
      .wdata (mem_readdata),
      .re    (pix_en),
      .raddr (pix_x),
      .rdata (bank_rdata[gi])
    );
  end

`ifdef PIX_FETCH_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt_reg <= '0;
    end else if (underrun_set) begin
      if (underrun_cnt_reg != 16'hFFFF) underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
    end else if (flag_clr) begin
      underrun_cnt_reg <= '0;
    end
  end

  assign underrun_cnt = underrun_cnt_reg;
`endif

  assign color       = rd_valid_reg ? bank_rdata[rd_sel_reg] : BLANK_PIX;
  assign mem_address = mem_address_reg;
  assign mem_read    = mem_read_reg;
  assign busy        = busy_reg;
  assign underrun    = underrun_reg;
  assign req_err     = req_err_reg;

endmodule

// File: tb/tb_pix_line_fetch.sv
// Scoreboard bench for pix_line_fetch with a pipelined memory model.
module tb_pix_line_fetch;

  localparam int W  = 300;
  localparam int AW = 18;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] offset = '0;
  logic          line_req = 1'b0;
  logic [8:0]    line_idx = '0;
  logic          line_swap = 1'b0;
  logic          pix_en = 1'b0;
  logic [8:0]    pix_x = '0;
  logic [7:0]    color;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic          mem_waitrequest = 1'b0;
  logic [7:0]    mem_readdata = '0;
  logic          mem_readdatavalid = 1'b0;
  logic          busy;
  logic          underrun;
  logic          req_err;
  logic          flag_clr = 1'b0;
`ifdef PIX_FETCH_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  pix_line_fetch #(.IMG_W(300), .IMG_H(300), .ADDR_W(AW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .offset(offset),
    .line_req(line_req), .line_idx(line_idx), .line_swap(line_swap),
    .pix_en(pix_en), .pix_x(pix_x), .color(color),
    .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .busy(busy), .underrun(underrun), .req_err(req_err), .flag_clr(flag_clr)
`ifdef PIX_FETCH_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] d;
    int         due;
  } rsp_t;

  rsp_t          rsp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [7:0]    pix_q[$];
  int lat = 2;
  bit wait_toggle = 1'b0;
  int ncyc = 0, n_acc = 0, n_val = 0, max_out = 0, first_acc = -1, last_acc = -1;

  function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  // Memory: accepts on the edge following each negedge, answers lat cycles later in order.
  always @(negedge clk) begin : mem_model
    logic [AW-1:0] exp_a;
    rsp_t r;
    ncyc++;
    if (!reset_n) begin
      rsp_q.delete();
      mem_readdatavalid = 1'b0;
      mem_waitrequest = 1'b0;
    end else begin
      mem_waitrequest = wait_toggle ? ~mem_waitrequest : 1'b0;
      if (mem_read && !mem_waitrequest) begin
        n_acc++;
        if (first_acc < 0) first_acc = ncyc;
        last_acc = ncyc;
        total++;
        if (addr_q.size() == 0) begin
          bad++;
          $display("FAIL addr_unexpected: mem_address=%0d, required no request", mem_address);
        end else begin
          exp_a = addr_q.pop_front();
          if (mem_address !== exp_a) begin
            bad++;
            $display("FAIL addr_seq: mem_address=%0d, required %0d", mem_address, exp_a);
          end
        end
        rsp_q.push_back('{d: mem_val(mem_address), due: ncyc + lat});
      end
      mem_readdatavalid = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= ncyc) begin
        r = rsp_q.pop_front();
        mem_readdatavalid = 1'b1;
        mem_readdata = r.d;
        n_val++;
      end
      if (n_acc - n_val > max_out) max_out = n_acc - n_val;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_line(input int base, input int idx);
    for (int i = 0; i < W; i++) addr_q.push_back(AW'(base + idx * W + i));
  endtask

  task automatic pulse_req(input int idx);
    line_idx = 9'(idx);
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
  endtask

  task automatic pulse_swap();
    line_swap = 1'b1;
    tick();
    line_swap = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin
      tick();
      c++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  // lbase < 0 means the whole line must read back as zero.
  task automatic read_range(input string name, input int lo, input int hi, input int lbase);
    logic [7:0] e;
    for (int x = lo; x <= hi; x++) begin
      pix_en = 1'b1;
      pix_x = 9'(x);
      pix_q.push_back((lbase >= 0 && x < W) ? mem_val(AW'(lbase + x)) : 8'h00);
      tick();
      e = pix_q.pop_front();
      total++;
      if (color !== e) begin
        bad++;
        $display("FAIL %s x=%0d: color=%02h, required %02h", name, x, color, e);
      end
    end
    pix_en = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    tick(2);
    total += 6;
    if (color !== 8'h00) begin bad++; $display("FAIL rst_color: got %02h, required 00", color); end
    if (mem_read !== 1'b0) begin bad++; $display("FAIL rst_mem_read: got %b, required 0", mem_read); end
    if (mem_address !== '0) begin bad++; $display("FAIL rst_addr: got %0d, required 0", mem_address); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b, required 0", underrun); end
    if (req_err !== 1'b0) begin bad++; $display("FAIL rst_req_err: got %b, required 0", req_err); end
    reset_n = 1'b1;
    tick(2);
    read_range("rst_blank", 5, 6, -1);
  endtask

  task automatic test_basic();
    offset = AW'(1000);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    lat = 2;
    first_acc = -1;
    push_line(1000, 2);
    pulse_req(2);
    total += 2;
    if (mem_read !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_cycle1: mem_read=%b busy=%b, required 0 1", mem_read, busy);
    end
    tick();
    if (mem_read !== 1'b1) begin bad++; $display("FAIL basic_cycle2: mem_read=%b, required 1", mem_read); end
    wait_idle("basic", 2000);
    total += 2;
    if (last_acc - first_acc !== W - 1) begin
      bad++;
      $display("FAIL basic_rate: span=%0d cycles, required %0d", last_acc - first_acc, W - 1);
    end
    if (addr_q.size() !== 0) begin bad++; $display("FAIL basic_count: %0d left, required 0", addr_q.size()); end
    pulse_swap();
    read_range("basic_px5", 5, 5, 1600);
    read_range("basic_line", 0, W - 1, 1600);
    read_range("basic_oob", 305, 315, 1600);
  endtask

  task automatic test_waitreq();
    int v0;
    wait_toggle = 1'b1;
    lat = 6;
    max_out = 0;
    v0 = n_val;
    push_line(1000, 3);
    pulse_req(3);
    wait_idle("waitreq", 5000);
    total += 3;
    if (max_out > MO) begin bad++; $display("FAIL waitreq_outst: max=%0d, required <= %0d", max_out, MO); end
    if (n_val - v0 !== W) begin bad++; $display("FAIL waitreq_valids: got %0d before idle, required %0d", n_val - v0, W); end
    if (addr_q.size() !== 0) begin bad++; $display("FAIL waitreq_count: %0d left, required 0", addr_q.size()); end
    wait_toggle = 1'b0;
    lat = 2;
    tick(2);
    pulse_swap();
    read_range("waitreq_line", 0, W - 1, 1900);
  endtask

  task automatic test_swap_timing();
    line_swap = 1'b1;
    pix_en = 1'b1;
    pix_x = 9'd7;
    tick();
    line_swap = 1'b0;
    total += 2;
    if (color !== mem_val(AW'(1907))) begin
      bad++;
      $display("FAIL swap_same_cycle: color=%02h, required %02h", color, mem_val(AW'(1907)));
    end
    tick();
    if (color !== mem_val(AW'(1607))) begin
      bad++;
      $display("FAIL swap_next_cycle: color=%02h, required %02h", color, mem_val(AW'(1607)));
    end
    pix_en = 1'b0;
    pulse_swap();
  endtask

  task automatic test_abort();
    int a0, a1, c;
    a0 = n_acc;
    push_line(1000, 5);
    pulse_req(5);
    c = 0;
    while (n_acc - a0 < 100 && c < 2000) begin
      tick();
      c++;
    end
    total++;
    if (n_acc - a0 < 100) begin bad++; $display("FAIL abort_reach100: accepts=%0d, required 100", n_acc - a0); end
    pulse_swap();
    a1 = n_acc;
    total += 2;
    if (mem_read !== 1'b0) begin bad++; $display("FAIL abort_drop: mem_read=%b, required 0", mem_read); end
    if (underrun !== 1'b1) begin bad++; $display("FAIL abort_underrun: got %b, required 1", underrun); end
    wait_idle("abort", 200);
    tick(5);
    total++;
    if (n_acc !== a1) begin bad++; $display("FAIL abort_more_reqs: got %0d extra, required 0", n_acc - a1); end
`ifdef PIX_FETCH_UNDERRUN_CNT_EN
    total++;
    if (underrun_cnt !== 16'd1) begin bad++; $display("FAIL abort_cnt: got %0d, required 1", underrun_cnt); end
`endif
    addr_q.delete();
    read_range("abort_new", 0, 49, 2500);
    read_range("abort_kept", 150, W - 1, 1600);
  endtask

  task automatic test_req_err();
    int a0;
    a0 = n_acc;
    total++;
    if (req_err !== 1'b0) begin bad++; $display("FAIL reqerr_pre: got %b, required 0", req_err); end
    push_line(1000, 4);
    pulse_req(4);
    tick(5);
    pulse_req(7);
    total++;
    if (req_err !== 1'b1) begin bad++; $display("FAIL reqerr_set: got %b, required 1", req_err); end
    wait_idle("reqerr", 2000);
    total += 2;
    if (n_acc - a0 !== W) begin bad++; $display("FAIL reqerr_fetch: accepts=%0d, required %0d", n_acc - a0, W); end
    if (addr_q.size() !== 0) begin bad++; $display("FAIL reqerr_count: %0d left, required 0", addr_q.size()); end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    total += 2;
    if (underrun !== 1'b0) begin bad++; $display("FAIL clr_underrun: got %b, required 0", underrun); end
    if (req_err !== 1'b0) begin bad++; $display("FAIL clr_req_err: got %b, required 0", req_err); end
`ifdef PIX_FETCH_UNDERRUN_CNT_EN
    total++;
    if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL clr_cnt: got %0d, required 0", underrun_cnt); end
`endif
    pulse_swap();
    read_range("reqerr_line", 0, 40, 2200);
  endtask

  task automatic test_blank();
    int a0;
    a0 = n_acc;
    pulse_req(300);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL blank_busy: got %b at cycle %0d, required 0", busy, i); end
      tick();
    end
    total += 2;
    if (n_acc !== a0) begin bad++; $display("FAIL blank_reqs: got %0d, required 0", n_acc - a0); end
    if (req_err !== 1'b0) begin bad++; $display("FAIL blank_req_err: got %b, required 0", req_err); end
    pulse_swap();
    read_range("blank_line", 0, 511, -1);
  endtask

  task automatic test_reset_mid();
    int c;
    push_line(1000, 6);
    pulse_req(6);
    c = 0;
    while (n_acc < 20 + c && c < 0) c++;
    tick(25);
    pulse_req(9);
    #2 reset_n = 1'b0;
    #1;
    total += 3;
    if (mem_read !== 1'b0) begin bad++; $display("FAIL midrst_mem_read: got %b, required 0", mem_read); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    if (req_err !== 1'b0) begin bad++; $display("FAIL midrst_req_err: got %b, required 0", req_err); end
    tick(3);
    addr_q.delete();
    reset_n = 1'b1;
    tick(2);
    read_range("midrst_blank", 5, 5, -1);
    push_line(0, 6);
    pulse_req(6);
    wait_idle("midrst", 2000);
    total++;
    if (addr_q.size() !== 0) begin bad++; $display("FAIL midrst_count: %0d left, required 0", addr_q.size()); end
    pulse_swap();
    read_range("midrst_line", 0, W - 1, 1800);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_waitreq();
    test_swap_timing();
    test_abort();
    test_req_err();
    test_blank();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
